// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
// Optional statistics feature is enabled by the REG_ARB_STATS_EN macro.
package reg_arb_pkg;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      COOL  = 2'd2
   } state_t;

   // Width of the cooldown counter (GAP is limited to 0..15).
   localparam int CNT_W   = 4;
   // Width of the saturating write counter.
   localparam int STATS_W = 16;

   // Width of a requester index.
   function automatic int id_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching ptr+1, ptr+2, ... with wrap at NUM_REQ.
module rr_pick
   import reg_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [ID_W-1:0]    winner,
   output logic [NUM_REQ-1:0] onehot
);

   // Index ptr+k, folded back into 0..NUM_REQ-1; k never exceeds NUM_REQ,
   // so a single subtraction is enough.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s > NUM_REQ - 1) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // Scan candidates in priority order; the first hit wins.
   always_comb begin
      any    = 1'b0;
      winner = '0;
      onehot = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!any && req[wrap_add(ptr, k)]) begin
            any    = 1'b1;
            winner = wrap_add(ptr, k);
         end
      end
      if (any) onehot = NUM_REQ'(1) << winner;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared W-bit register.
// Handshake: req[i] is a level held until the registered one-cycle gnt[i]
// pulse; the requester drops req[i] on the edge that ends its gnt cycle.
// req is only looked at in IDLE and wdata only on the grant edge.
// Optional REG_ARB_STATS_EN adds wr_cnt (saturating grant count) and last_id.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int W       = 8,
   parameter  int GAP     = 1,
   localparam int ID_W    = id_w(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*W-1:0] wdata,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [W-1:0]         q,
   output logic                 q_vld,
   output logic                 busy,
`ifdef REG_ARB_STATS_EN
   output logic [STATS_W-1:0]   wr_cnt,
   output logic [ID_W-1:0]      last_id,
`endif
   output state_t               state_dbg
);

   // Cooldown counter load value; unused when GAP is 0.
   localparam logic [CNT_W-1:0] CNT_INIT = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [ID_W-1:0]      ptr;
   logic                 pick_any;
   logic [ID_W-1:0]      pick_id;
   logic [NUM_REQ-1:0]   pick_onehot;
   logic                 do_grant;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .any    (pick_any),
      .winner (pick_id),
      .onehot (pick_onehot)
   );

   // Next-state logic; clr forces IDLE and suppresses any grant.
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = GRANT;
               do_grant  = 1'b1;
            end
         end
         GRANT:   state_nxt = (GAP > 0) ? COOL : IDLE;
         COOL:    if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clr) begin
         state_nxt = IDLE;
         do_grant  = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Shared register, grant pulse, round-robin pointer and cooldown counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q     <= '0;
         q_vld <= 1'b0;
         gnt   <= '0;
         cnt   <= '0;
         ptr   <= ID_W'(NUM_REQ - 1);
      end else if (clr) begin
         q     <= '0;
         q_vld <= 1'b0;
         gnt   <= '0;
         cnt   <= '0;
      end else begin
         gnt <= do_grant ? pick_onehot : '0;
         if (do_grant) begin
            q     <= wdata[int'(pick_id)*W +: W];
            q_vld <= 1'b1;
            ptr   <= pick_id;
         end
         if (state == GRANT) cnt <= CNT_INIT;
         else if (state == COOL && cnt != '0) cnt <= cnt - 1'b1;
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

`ifdef REG_ARB_STATS_EN
   // Grant statistics: saturating write count and latest winner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_cnt  <= '0;
         last_id <= '0;
      end else if (clr) begin
         wr_cnt  <= '0;
         last_id <= '0;
      end else if (do_grant) begin
         if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
         last_id <= pick_id;
      end
   end
`endif

endmodule
